// File: rtl/lc3b_control.sv
// ---------------------------------------------------------------------------
// lc3b_control
//
// Moore control FSM for the multi-cycle LC-3b datapath. It sequences fetch,
// decode and execute for ADD, AND, NOT, LDR, STR and BR. Every other opcode
// is decoded as a no-op that goes straight back to fetch.
//
// Ports
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset (forces FETCH1)
//   opcode[3:0]     in   IR[15:12] from the datapath
//   br_en           in   condition codes match IR[11:9]
//   mem_resp        in   memory has completed the current read/write
//   pcmux_sel       out  0: PC+2, 1: branch target
//   load_pc         out  PC register load
//   storemux_sel    out  source-register select for the store path
//   load_ir         out  IR load
//   marmux_sel      out  0: ALU result, 1: PC
//   load_mar        out  MAR load
//   mdrmux_sel      out  0: ALU result, 1: memory read data
//   load_mdr        out  MDR load
//   load_regfile    out  register file write
//   alumux_sel      out  0: SR2, 1: offset
//   regfilemux_sel  out  0: ALU result, 1: MDR
//   load_cc         out  condition-code load
//   alu_op[2:0]     out  ALU function (add/and/not/pass/sll/srl/sra)
//   mem_read        out  memory read strobe
//   mem_write       out  memory write strobe
//   mem_byte_enable out  always 2'b11 (word accesses only)
// ---------------------------------------------------------------------------
module lc3b_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] opcode,
   input  logic       br_en,
   input  logic       mem_resp,
   output logic       pcmux_sel,
   output logic       load_pc,
   output logic       storemux_sel,
   output logic       load_ir,
   output logic       marmux_sel,
   output logic       load_mar,
   output logic       mdrmux_sel,
   output logic       load_mdr,
   output logic       load_regfile,
   output logic       alumux_sel,
   output logic       regfilemux_sel,
   output logic       load_cc,
   output logic [2:0] alu_op,
   output logic       mem_read,
   output logic       mem_write,
   output logic [1:0] mem_byte_enable
);

   // ALU function encoding shared with the datapath ALU
   localparam logic [2:0] alu_add  = 3'd0;
   localparam logic [2:0] alu_and  = 3'd1;
   localparam logic [2:0] alu_not  = 3'd2;
   localparam logic [2:0] alu_pass = 3'd3;
   localparam logic [2:0] alu_sll  = 3'd4;
   localparam logic [2:0] alu_srl  = 3'd5;
   localparam logic [2:0] alu_sra  = 3'd6;

   // Opcodes this controller executes
   localparam logic [3:0] op_br  = 4'b0000;
   localparam logic [3:0] op_add = 4'b0001;
   localparam logic [3:0] op_and = 4'b0101;
   localparam logic [3:0] op_ldr = 4'b0110;
   localparam logic [3:0] op_str = 4'b0111;
   localparam logic [3:0] op_not = 4'b1001;

   typedef enum logic [3:0] {
      FETCH1    = 4'd0,
      FETCH2    = 4'd1,
      FETCH3    = 4'd2,
      DECODE    = 4'd3,
      S_ADD     = 4'd4,
      S_AND     = 4'd5,
      S_NOT     = 4'd6,
      CALC_ADDR = 4'd7,
      LDR1      = 4'd8,
      LDR2      = 4'd9,
      STR1      = 4'd10,
      STR2      = 4'd11,
      BR        = 4'd12,
      BR_TAKEN  = 4'd13
   } state_t;

   state_t state;
   state_t next_state;

   // State register. Reset is asynchronous so that a pending memory strobe
   // drops immediately, abandoning any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH1;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Wait states hold until mem_resp; mem_resp is ignored
   // everywhere else. Encodings outside the enum fall into the default arm
   // and recover to FETCH1.
   always_comb begin
      next_state = FETCH1;
      case (state)
         FETCH1: next_state = FETCH2;
         FETCH2: next_state = mem_resp ? FETCH3 : FETCH2;
         FETCH3: next_state = DECODE;
         DECODE: begin
            case (opcode)
               op_add:         next_state = S_ADD;
               op_and:         next_state = S_AND;
               op_not:         next_state = S_NOT;
               op_ldr, op_str: next_state = CALC_ADDR;
               op_br:          next_state = BR;
               default:        next_state = FETCH1;
            endcase
         end
         S_ADD, S_AND, S_NOT: next_state = FETCH1;
         CALC_ADDR: begin
            if (opcode == op_ldr) begin
               next_state = LDR1;
            end else if (opcode == op_str) begin
               next_state = STR1;
            end else begin
               next_state = FETCH1;
            end
         end
         LDR1:     next_state = mem_resp ? LDR2 : LDR1;
         LDR2:     next_state = FETCH1;
         STR1:     next_state = STR2;
         STR2:     next_state = mem_resp ? FETCH1 : STR2;
         BR:       next_state = br_en ? BR_TAKEN : FETCH1;
         BR_TAKEN: next_state = FETCH1;
         default:  next_state = FETCH1;
      endcase
   end

   // Output decode: a pure function of state. Strobes in wait states stay
   // high through the mem_resp cycle, and load_mdr is held so the MDR
   // captures the data present in that final cycle.
   always_comb begin
      pcmux_sel       = 1'b0;
      load_pc         = 1'b0;
      storemux_sel    = 1'b0;
      load_ir         = 1'b0;
      marmux_sel      = 1'b0;
      load_mar        = 1'b0;
      mdrmux_sel      = 1'b0;
      load_mdr        = 1'b0;
      load_regfile    = 1'b0;
      alumux_sel      = 1'b0;
      regfilemux_sel  = 1'b0;
      load_cc         = 1'b0;
      alu_op          = alu_add;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 2'b11;
      case (state)
         FETCH1: begin
            marmux_sel = 1'b1;
            load_mar   = 1'b1;
            pcmux_sel  = 1'b0;
            load_pc    = 1'b1;
         end
         FETCH2, LDR1: begin
            mem_read   = 1'b1;
            mdrmux_sel = 1'b1;
            load_mdr   = 1'b1;
         end
         FETCH3: begin
            load_ir = 1'b1;
         end
         S_ADD, S_AND, S_NOT: begin
            if (state == S_AND) begin
               alu_op = alu_and;
            end else if (state == S_NOT) begin
               alu_op = alu_not;
            end else begin
               alu_op = alu_add;
            end
            alumux_sel     = 1'b0;
            regfilemux_sel = 1'b0;
            load_regfile   = 1'b1;
            load_cc        = 1'b1;
         end
         CALC_ADDR: begin
            alumux_sel = 1'b1;
            alu_op     = alu_add;
            marmux_sel = 1'b0;
            load_mar   = 1'b1;
         end
         LDR2: begin
            regfilemux_sel = 1'b1;
            load_regfile   = 1'b1;
            load_cc        = 1'b1;
         end
         STR1: begin
            storemux_sel = 1'b1;
            alu_op       = alu_pass;
            mdrmux_sel   = 1'b0;
            load_mdr     = 1'b1;
         end
         STR2: begin
            mem_write = 1'b1;
         end
         BR_TAKEN: begin
            pcmux_sel = 1'b1;
            load_pc   = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Shift encodings are part of the ALU function set but no executed
   // instruction selects them; this keeps them visibly reserved.
   logic [2:0] shift_ops_unused;
   assign shift_ops_unused = alu_sll ^ alu_srl ^ alu_sra;

endmodule
